// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID pipeline register.
// Handles the memory handshake, wait states, stalls and branch redirects.
module fetch_stage #(
  parameter int unsigned N        = 32,
  parameter logic [N-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         StallF,
  input  logic         StallD,
  input  logic         FlushD,
  input  logic         BranchTakenE,
  input  logic [N-1:0] BranchTargetE,
  output logic         imem_req,
  output logic [N-1:0] imem_addr,
  input  logic [N-1:0] imem_rdata,
  input  logic         imem_ready,
  output logic [N-1:0] InstrD,
  output logic [N-1:0] PCD,
  output logic [N-1:0] PCPlus8D,
  output logic         ValidD
);

  typedef enum logic [1:0] {READY, WAIT, DISCARD, HOLD} state_t;

  state_t       state, state_n;
  logic [N-1:0] pcf, pcf_n;
  logic [N-1:0] addr_hold, addr_hold_n;
  logic [N-1:0] buf_instr, buf_pc;
  logic         load_mem, load_buf, cap_buf;

  assign imem_req  = ((state == READY) && !StallF) || (state == WAIT) || (state == DISCARD);
  assign imem_addr = (state == DISCARD) ? addr_hold : pcf;

  always_comb begin
    state_n     = state;
    pcf_n       = pcf;
    addr_hold_n = addr_hold;
    load_mem    = 1'b0;
    load_buf    = 1'b0;
    cap_buf     = 1'b0;
    if (BranchTakenE) begin
      pcf_n = BranchTargetE & ~N'(3);
      unique case (state)
        // An outstanding request that has not completed must keep its address
        // until the memory answers, so it moves to DISCARD.
        READY: begin
          if (imem_req && !imem_ready) begin
            state_n     = DISCARD;
            addr_hold_n = pcf;
          end
        end
        WAIT: begin
          if (imem_ready) begin
            state_n = READY;
          end else begin
            state_n     = DISCARD;
            addr_hold_n = pcf;
          end
        end
        DISCARD: if (imem_ready) state_n = READY;
        HOLD:    state_n = READY;
        default: state_n = READY;
      endcase
    end else begin
      unique case (state)
        READY: begin
          if (!StallF) begin
            if (imem_ready) begin
              pcf_n = pcf + N'(4);
              if (StallD) begin
                cap_buf = 1'b1;
                state_n = HOLD;
              end else begin
                load_mem = 1'b1;
              end
            end else begin
              state_n = WAIT;
            end
          end
        end
        WAIT: begin
          if (imem_ready) begin
            pcf_n = pcf + N'(4);
            if (StallD) begin
              cap_buf = 1'b1;
              state_n = HOLD;
            end else begin
              load_mem = 1'b1;
              state_n  = READY;
            end
          end
        end
        DISCARD: if (imem_ready) state_n = READY;
        HOLD: begin
          if (!StallD) begin
            load_buf = 1'b1;
            state_n  = READY;
          end
        end
        default: state_n = READY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= READY;
      pcf       <= RESET_PC;
      addr_hold <= '0;
      buf_instr <= '0;
      buf_pc    <= '0;
    end else begin
      state     <= state_n;
      pcf       <= pcf_n;
      addr_hold <= addr_hold_n;
      if (cap_buf) begin
        buf_instr <= imem_rdata;
        buf_pc    <= pcf;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      InstrD   <= '0;
      PCD      <= '0;
      PCPlus8D <= '0;
      ValidD   <= 1'b0;
    end else if (BranchTakenE || FlushD) begin
      InstrD <= '0;
      ValidD <= 1'b0;
    end else if (StallD) begin
      InstrD <= InstrD;
    end else if (load_mem) begin
      InstrD   <= imem_rdata;
      PCD      <= pcf;
      PCPlus8D <= pcf + N'(8);
      ValidD   <= 1'b1;
    end else if (load_buf) begin
      InstrD   <= buf_instr;
      PCD      <= buf_pc;
      PCPlus8D <= buf_pc + N'(8);
      ValidD   <= 1'b1;
    end else begin
      InstrD <= '0;
      ValidD <= 1'b0;
    end
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage plus IF/ID pipeline register of the scalar pipeline. It generates the fetch PC, runs a request/ready handshake with instruction memory, and absorbs stalls, wait states and branch redirects. It delivers InstrD, PCD and PCPlus8D to decode, where PCPlus8D is the value the register file writes into r15 every cycle.

## Interface
- N, 32, data/address width
- RESET_PC, 32'h0, fetch address after reset
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- StallF  in  1  hazard unit: do not launch a new fetch
- StallD  in  1  hazard unit: hold IF/ID register
- FlushD  in  1  hazard unit: load bubble into IF/ID
- BranchTakenE  in  1  redirect fetch to BranchTargetE
- BranchTargetE  in  N  redirect target
- imem_req  out  1  fetch request valid
- imem_addr  out  N  fetch address
- imem_rdata  in  N  instruction, valid in the cycle imem_req&imem_ready
- imem_ready  in  1  memory completes the current request this cycle
- InstrD  out  N  instruction in decode (0 when bubble)
- PCD  out  N  address of InstrD
- PCPlus8D  out  N  PCD+8, to register file R15
- ValidD  out  1  InstrD is a real instruction

## Operation
- Internal regs: PCF (N), state {READY, WAIT, DISCARD, HOLD}, addr_hold (N), buffer (instr + pc).
- Completion = imem_req & imem_ready. The memory may respond in the same cycle as the request (zero-wait).
- imem_req = (READY & !StallF) | WAIT | DISCARD; 0 in HOLD.
- imem_addr = addr_hold in DISCARD, else PCF. Must stay stable while imem_req=1 and imem_ready=0.
- READY:
  - StallF: no request; PCF held.
  - Request without ready → WAIT.
  - Completion → "deliver".
- WAIT: StallF is ignored because the request is already outstanding.
  - Completion → "deliver", then READY (or HOLD, per deliver rules).
- Deliver:
  - BranchTakenE same cycle: drop the data.
  - Else if StallD: capture into buffer → HOLD.
  - Else load IF/ID (InstrD=rdata, PCD=PCF, PCPlus8D=PCF+8, ValidD=1).
  - PCF ← PCF+4 in both non-redirect cases.
- Redirect (BranchTakenE=1), any state:
  - PCF ← {BranchTargetE[N-1:2],2'b00}; IF/ID ← bubble (regardless of StallD); buffer dropped.
  - WAIT without completion → DISCARD, with addr_hold ← current PCF.
  - HOLD → READY.
  - DISCARD stays DISCARD; addr_hold unchanged.
- DISCARD: wait for imem_ready, drop the data, → READY. The next fetch uses the PCF already holding the target.
- HOLD: when StallD=0, load IF/ID from buffer → READY. PCF already points to the next instruction.
- IF/ID update priority: rst > redirect/FlushD (bubble) > StallD (hold) > deliver/buffer > bubble. If decode advances and nothing is delivered, load a bubble.
- Bubble: InstrD=0, ValidD=0. PCD and PCPlus8D hold their previous values.
- Arithmetic: PC+4 and PC+8 are modulo 2^N and wrap silently.

## Timing
- Reset (async, immediate): PCF=RESET_PC, state=READY, InstrD=0, PCD=0, PCPlus8D=0, ValidD=0, buffer cleared. imem_req follows !StallF combinationally.
- Zero-wait memory: one instruction per cycle. An instruction requested in cycle t appears on InstrD after edge t+1.
- Each wait-state cycle inserts one bubble (unless StallD holds IF/ID).
- Redirect in cycle t: target requested in cycle t+1 (READY/HOLD) or the cycle after the discarded response.
- Outputs are all registered except imem_req and imem_addr.

## Test plan
- Reset with RESET_PC=0, imem_ready=1, mem[0]=0xE3A00001, mem[4]=0xE3A01002 → after edge 1: InstrD=0xE3A00001, PCD=0, PCPlus8D=8, ValidD=1. After edge 2: PCD=4, PCPlus8D=0xC.
- imem_ready low 2 cycles at addr 0x8 → imem_addr=0x8 for 3 cycles, ValidD=0 for 2 cycles, then InstrD=mem[8], PCD=0x8.
- BranchTakenE with target 0x43 while WAIT at 0x8 → ValidD=0, imem_addr stays 0x8 until ready, data dropped. Next request at 0x40, then PCD=0x40, PCPlus8D=0x48.
- StallD=1 at completion of 0xC → InstrD unchanged, imem_req=0 (HOLD). StallD=0 → next edge InstrD=mem[0xC], then fetch of 0x10 resumes.
- RESET_PC=0xFFFFFFFC → PCD=0xFFFFFFFC, PCPlus8D=0x4, next imem_addr=0x0.
- rst asserted mid-WAIT between clock edges → ValidD=0 and imem_addr=RESET_PC immediately; the stale imem_ready after reset is treated as completion for RESET_PC.
